// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared accelerator definitions. Holds the default array
//               geometry, the skew feeder state encoding, and helpers for
//               sizing lane slices and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

  localparam int DEF_ARR_SIZE = 4;
  localparam int DEF_DATA_W   = 32;

  // IDLE: empty tile, LOAD: partially filled, FULL: tile complete, FEED: streaming
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_FEED = 2'd3
  } feeder_state_t;

  // Total width of a bus carrying n lanes of w bits each
  function automatic int bus_w(input int n, input int w);
    return n * w;
  endfunction

  // Low bit of lane `lane` on a bus with w-bit lanes
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  // Bits needed to index n entries, never less than one
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the values 0..n inclusive
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : skew_feeder_if
// Description : Tile-load and array-feed bundle of the skew feeder. The
//               master side loads rows and requests feeds; the slave side
//               is the feeder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface skew_feeder_if
  import acc_pkg::*;
#(
  parameter int ARR_SIZE = DEF_ARR_SIZE,
  parameter int DATA_W   = DEF_DATA_W
);

  logic                         flush;
  logic                         load_valid;
  logic                         load_ready;
  logic [ARR_SIZE*DATA_W-1:0]   load_data;
  logic                         start;
  logic [ARR_SIZE*DATA_W-1:0]   array_data;
  logic [ARR_SIZE-1:0]          array_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output flush,
    output load_valid,
    output load_data,
    output start,
    input  load_ready,
    input  array_data,
    input  array_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  flush,
    input  load_valid,
    input  load_data,
    input  start,
    output load_ready,
    output array_data,
    output array_valid,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : skew_feeder
// Description : Collects an N x N operand tile row by row, then streams it
//               into a systolic MAC array with a one-cycle skew per lane:
//               lane i carries tile[s-i][i] on feed step s. The skew is
//               derived from a single step counter, not per-lane delays.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_feeder
  import acc_pkg::*;
#(
  parameter int ARR_SIZE = DEF_ARR_SIZE,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  wire logic   clk,
  input  wire logic   rst,
  skew_feeder_if.slave bus
);

  localparam int c_IDX_W  = idx_w(ARR_SIZE);
  localparam int c_CNT_W  = cnt_w(ARR_SIZE);
  localparam int c_STEP_W = cnt_w(2 * ARR_SIZE);
  localparam int c_BUS_W  = bus_w(ARR_SIZE, DATA_W);

  localparam logic [c_CNT_W-1:0]  c_ROWS_FULL = c_CNT_W'(ARR_SIZE);
  // Steps 0..2N-2 emit operands; step 2N-1 is the wrap-up edge
  localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(2 * ARR_SIZE - 1);

  feeder_state_t         r_state;
  logic [c_CNT_W-1:0]    r_row_cnt;
  logic [c_STEP_W-1:0]   r_step;
  logic [DATA_W-1:0]     r_tile [ARR_SIZE][ARR_SIZE];  // [row][lane]
  logic [c_BUS_W-1:0]    r_array_data;
  logic [ARR_SIZE-1:0]   r_array_valid;
  logic                  r_done;

  logic                  w_load_ready;
  logic                  w_accept;
  logic [c_CNT_W-1:0]    w_row_cnt_inc;
  logic [ARR_SIZE-1:0]   w_step_valid;
  logic [c_BUS_W-1:0]    w_step_data;

  // Rows are taken only while the tile still has room; flush suppresses any write
  always_comb begin
    w_load_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    w_accept      = w_load_ready && bus.load_valid && !bus.flush;
    w_row_cnt_inc = r_row_cnt + 1'b1;
  end

  // Operands for the current feed step: lane i reads row (step - i) while that row exists
  always_comb begin
    int row;
    row          = 0;
    w_step_valid = '0;
    w_step_data  = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      row = int'(r_step) - i;
      if ((row >= 0) && (row < ARR_SIZE)) begin
        w_step_valid[i] = 1'b1;
        w_step_data[lane_lsb(i, DATA_W) +: DATA_W] = r_tile[row[c_IDX_W-1:0]][i];
      end
    end
  end

  // Tile storage is left unreset: only rows written for the current tile are ever read
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < ARR_SIZE; i++) begin
        r_tile[r_row_cnt[c_IDX_W-1:0]][i] <= bus.load_data[lane_lsb(i, DATA_W) +: DATA_W];
      end
    end
  end

  // Control FSM with registered array outputs and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_row_cnt     <= '0;
      r_step        <= '0;
      r_array_valid <= '0;
      r_array_data  <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state       <= ST_IDLE;
        r_row_cnt     <= '0;
        r_step        <= '0;
        r_array_valid <= '0;
        r_array_data  <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_LOAD: begin
            if (w_accept) begin
              r_row_cnt <= w_row_cnt_inc;
              r_state   <= (w_row_cnt_inc == c_ROWS_FULL) ? ST_FULL : ST_LOAD;
            end
          end
          ST_FULL: begin
            if (bus.start) begin
              r_state <= ST_FEED;
              r_step  <= '0;
            end
          end
          ST_FEED: begin
            if (r_step == c_LAST_STEP) begin
              r_state       <= ST_IDLE;
              r_row_cnt     <= '0;
              r_step        <= '0;
              r_array_valid <= '0;
              r_array_data  <= '0;
              r_done        <= 1'b1;
            end else begin
              r_array_valid <= w_step_valid;
              r_array_data  <= w_step_data;
              r_step        <= r_step + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.array_valid = r_array_valid;
  assign bus.array_data  = r_array_data;
  assign bus.done        = r_done;

endmodule
`default_nettype wire
